seg_scan: RTL

Multiplexed six-digit seven-segment scan driver for the clock's display path. It consumes the packed-BCD `h`, `min` and `sec` buses produced by the screen logic and drives common-anode digit enables and segment lines. A field shadow register keeps a frame from tearing, per-field blink supports set mode, and a guard interval suppresses ghosting. It sits between the top-level time outputs and the board pins.

---
 rtl/seg_scan.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan
// Description : Six-digit multiplexed seven-segment scan driver. Shows
//               packed-BCD hours/minutes/seconds on common-anode digits,
//               with a per-frame shadow latch, per-field blink, hour-tens
//               leading-zero blanking and an all-off guard at slot start.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int GUARD        = 16,
    parameter int BLINK_FRAMES = 64,
    parameter bit LZ_BLANK     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] h,
    input  logic [7:0] min,
    input  logic [7:0] sec,
    input  logic [2:0] blink,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int             CW          = $clog2(SCAN_DIV);
    localparam int             FW          = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0]  C_CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [FW-1:0]  C_FCNT_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [2:0]     C_DIG_LAST  = 3'd5;
    localparam logic [6:0]     C_SEG_BLANK = 7'h7F;
    localparam logic [5:0]     C_AN_OFF    = 6'h3F;

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_digit;
    logic [FW-1:0] r_fcnt;
    logic          r_phase;
    logic [7:0]    r_sh_h;
    logic [7:0]    r_sh_min;
    logic [7:0]    r_sh_sec;
    logic [2:0]    r_sh_blink;

    logic          w_slot_end;
    logic          w_frame_end;
    logic          w_guard;
    logic [3:0]    w_nib;
    logic          w_fblink;
    logic          w_dp;
    logic [6:0]    w_dec;
    logic [6:0]    w_seg;

    assign w_slot_end  = (r_cnt == C_CNT_LAST);
    assign w_frame_end = w_slot_end && (r_digit == C_DIG_LAST);

    // A zero-length guard would make the comparison constant, so only build it when needed.
    generate
        if (GUARD > 0) begin : g_guard
            localparam logic [CW-1:0] C_GUARD = CW'(GUARD);
            assign w_guard = (r_cnt < C_GUARD);
        end else begin : g_no_guard
            assign w_guard = 1'b0;
        end
    endgenerate

    // Slot counter and digit index: digit advances on each slot's terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_digit <= 3'd0;
        end else if (w_slot_end) begin
            r_cnt   <= '0;
            r_digit <= (r_digit == C_DIG_LAST) ? 3'd0 : r_digit + 3'd1;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // Shadow registers: inputs are sampled only at frame end so a frame never tears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_h     <= 8'h00;
            r_sh_min   <= 8'h00;
            r_sh_sec   <= 8'h00;
            r_sh_blink <= 3'b000;
        end else if (w_frame_end) begin
            r_sh_h     <= h;
            r_sh_min   <= min;
            r_sh_sec   <= sec;
            r_sh_blink <= blink;
        end
    end

    // Frame counter: blink phase flips every BLINK_FRAMES frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fcnt  <= '0;
            r_phase <= 1'b0;
        end else if (w_frame_end) begin
            if (r_fcnt == C_FCNT_LAST) begin
                r_fcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_fcnt  <= r_fcnt + 1'b1;
            end
        end
    end

    // Select the nibble, owning field's blink bit and colon for the current digit.
    always_comb begin
        w_nib    = 4'd0;
        w_fblink = 1'b0;
        w_dp     = 1'b1;
        case (r_digit)
            3'd0: begin w_nib = r_sh_h[7:4];   w_fblink = r_sh_blink[2]; end
            3'd1: begin w_nib = r_sh_h[3:0];   w_fblink = r_sh_blink[2]; w_dp = 1'b0; end
            3'd2: begin w_nib = r_sh_min[7:4]; w_fblink = r_sh_blink[1]; end
            3'd3: begin w_nib = r_sh_min[3:0]; w_fblink = r_sh_blink[1]; w_dp = 1'b0; end
            3'd4: begin w_nib = r_sh_sec[7:4]; w_fblink = r_sh_blink[0]; end
            3'd5: begin w_nib = r_sh_sec[3:0]; w_fblink = r_sh_blink[0]; end
            default: ;
        endcase
    end

    // BCD to active-low {g,f,e,d,c,b,a}; non-BCD nibbles show a dash.
    always_comb begin
        w_dec = 7'h3F;
        case (w_nib)
            4'd0: w_dec = 7'h40;
            4'd1: w_dec = 7'h79;
            4'd2: w_dec = 7'h24;
            4'd3: w_dec = 7'h30;
            4'd4: w_dec = 7'h19;
            4'd5: w_dec = 7'h12;
            4'd6: w_dec = 7'h02;
            4'd7: w_dec = 7'h78;
            4'd8: w_dec = 7'h00;
            4'd9: w_dec = 7'h10;
            default: w_dec = 7'h3F;
        endcase
    end

    // Blanking: blinking field in the off phase, or leading zero on hour tens.
    always_comb begin
        w_seg = w_dec;
        if (w_fblink && r_phase) begin
            w_seg = C_SEG_BLANK;
        end
        if (LZ_BLANK && (r_digit == 3'd0) && (w_nib == 4'd0)) begin
            w_seg = C_SEG_BLANK;
        end
    end

    // Registered outputs; the guard window keeps every anode off to avoid ghosting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= C_AN_OFF;
            seg <= C_SEG_BLANK;
            dp  <= 1'b1;
        end else if (w_guard) begin
            an  <= C_AN_OFF;
            seg <= C_SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(6'b000001 << r_digit);
            seg <= w_seg;
            dp  <= w_dp;
        end
    end

endmodule
`default_nettype wire
